// File: rtl/hazard_stall_ctrl.sv
// Decode-stage hazard unit: Tuse/Tnew register-hazard stall plus mult/div busy stall.
// Optional stall counter built only when HAZARD_STALL_PERF_EN is defined.
module hazard_stall_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_valid,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic [4:0]  d_dst,
  input  logic [1:0]  d_tnew,
  input  logic        d_md_start,
  input  logic        d_md_div,
  input  logic        d_md_use,
  output logic        stall,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        id_ex_we,
  output logic        id_ex_clr,
  output logic [31:0] perf_stall_cnt
);

  logic [4:0]       e_dst, m_dst;
  logic [1:0]       e_tnew, m_tnew;
  logic [CNT_W-1:0] md_cnt;

  logic hit_rs_e, hit_rt_e, hit_rs_m, hit_rt_m, md_stall;

  always_comb begin
    hit_rs_e = (d_rs != 5'd0) && (d_rs == e_dst) && (d_tuse_rs < e_tnew);
    hit_rt_e = (d_rt != 5'd0) && (d_rt == e_dst) && (d_tuse_rt < e_tnew);
    hit_rs_m = (d_rs != 5'd0) && (d_rs == m_dst) && (d_tuse_rs < m_tnew);
    hit_rt_m = (d_rt != 5'd0) && (d_rt == m_dst) && (d_tuse_rt < m_tnew);
    md_stall = d_md_use && (md_cnt != '0);
    stall    = d_valid && !reset &&
               (hit_rs_e || hit_rt_e || hit_rs_m || hit_rt_m || md_stall);
  end

  assign pc_we     = ~stall;
  assign if_id_we  = ~stall;
  assign id_ex_we  = 1'b1;
  assign id_ex_clr = stall;

  // Shadow pipeline: a stalled or empty D slot enters E as a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_dst  <= '0;
      e_tnew <= '0;
      m_dst  <= '0;
      m_tnew <= '0;
    end else begin
      m_dst  <= e_dst;
      m_tnew <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
      if (stall || !d_valid) begin
        e_dst  <= '0;
        e_tnew <= '0;
      end else begin
        e_dst  <= d_dst;
        e_tnew <= d_tnew;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      md_cnt <= '0;
    else if (d_valid && d_md_start && !stall)
      md_cnt <= d_md_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    else if (md_cnt != '0)
      md_cnt <= md_cnt - 1'b1;
  end

`ifdef HAZARD_STALL_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      perf_cnt <= '0;
    else if (stall)
      perf_cnt <= perf_cnt + 32'd1;
  end

  assign perf_stall_cnt = perf_cnt;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: expected control outputs queued per cycle,
// observed outputs queued by the driver, both popped and compared per scenario.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        d_valid = 1'b0;
  logic [4:0]  d_rs = '0, d_rt = '0, d_dst = '0;
  logic [1:0]  d_tuse_rs = 2'd3, d_tuse_rt = 2'd3, d_tnew = '0;
  logic        d_md_start = 1'b0, d_md_div = 1'b0, d_md_use = 1'b0;
  logic        stall, pc_we, if_id_we, id_ex_we, id_ex_clr;
  logic [31:0] perf_stall_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [4:0]  exp_q[$];
  logic [4:0]  obs_q[$];

  hazard_stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
    .stall(stall), .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
    .id_ex_clr(id_ex_clr), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  // One D-stage cycle: drive, queue expectation, sample away from the edge.
  task automatic drive(input logic v, input logic [4:0] rs, input logic [1:0] trs,
                       input logic [4:0] rt, input logic [1:0] trt,
                       input logic [4:0] dst, input logic [1:0] tnew,
                       input logic mds, input logic mdd, input logic mdu,
                       input logic rst, input logic e);
    @(negedge clk);
    d_valid = v; d_rs = rs; d_tuse_rs = trs; d_rt = rt; d_tuse_rt = trt;
    d_dst = dst; d_tnew = tnew; d_md_start = mds; d_md_div = mdd; d_md_use = mdu;
    reset = rst;
    exp_q.push_back({e, ~e, ~e, 1'b1, e});
    #1;
    obs_q.push_back({stall, pc_we, if_id_we, id_ex_we, id_ex_clr});
  endtask

  task automatic nop();
    drive(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    logic [4:0] e, o;
    drive(1, 0, 3, 0, 3, 0, 0, 0, 0, 1, 1, 0);
    drive(1, 0, 3, 0, 3, 0, 0, 0, 0, 1, 1, 0);
    nop();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_outputs got %b want %b", o, e); end
    end
    checks++;
    if (perf_stall_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_perf got %0d want 0", perf_stall_cnt);
    end
  endtask

  task automatic test_load_use();
    logic [4:0] e, o;
    drive(1, 0, 3, 0, 3, 1, 2, 0, 0, 0, 0, 0);   // lw $1
    drive(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 1);   // addu $3,$1,$2 stalls
    drive(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0);   // then issues
    nop(); nop();
    drive(1, 0, 3, 0, 3, 1, 2, 0, 0, 0, 0, 0);   // lw $1
    nop();
    drive(1, 1, 0, 0, 3, 3, 1, 0, 0, 0, 0, 1);   // tuse 0 two behind: M hit
    drive(1, 1, 0, 0, 3, 3, 1, 0, 0, 0, 0, 0);
    nop(); nop();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL load_use got %b want %b", o, e); end
    end
  endtask

  task automatic test_no_stall();
    logic [4:0] e, o;
    drive(1, 0, 3, 0, 3, 1, 2, 0, 0, 0, 0, 0);   // lw $1
    drive(1, 4, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0);   // sw $1,0($4)
    nop(); nop();
    drive(1, 0, 3, 0, 3, 0, 2, 0, 0, 0, 0, 0);   // lw $0
    drive(1, 0, 1, 0, 1, 3, 1, 0, 0, 0, 0, 0);   // addu $3,$0,$0
    nop(); nop();
    drive(1, 0, 3, 0, 3, 1, 2, 0, 0, 0, 0, 0);   // lw $1
    drive(1, 1, 3, 1, 3, 3, 1, 0, 0, 0, 0, 0);   // tuse 3 never stalls
    nop(); nop();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL no_stall got %b want %b", o, e); end
    end
  endtask

  task automatic test_md(input logic is_div, input int unsigned cyc);
    logic [4:0] e, o;
    drive(1, 0, 3, 0, 3, 0, 0, 1, is_div, 1, 0, 0);
    for (int unsigned i = 0; i < cyc; i++) drive(1, 0, 3, 0, 3, 5, 1, 0, 0, 1, 0, 1);
    drive(1, 0, 3, 0, 3, 5, 1, 0, 0, 1, 0, 0);
    nop(); nop();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL md_busy div=%0b got %b want %b", is_div, o, e);
      end
    end
  endtask

  task automatic test_overlap();
    logic [4:0] e, o;
    drive(1, 0, 3, 0, 3, 0, 0, 1, 0, 1, 0, 0);   // mult
    drive(1, 0, 3, 0, 3, 1, 2, 0, 0, 0, 0, 0);   // lw $1
    for (int unsigned i = 0; i < 4; i++) drive(1, 1, 1, 0, 3, 0, 0, 0, 0, 1, 0, 1);
    drive(1, 1, 1, 0, 3, 0, 0, 0, 0, 1, 0, 0);   // mthi $1 issues
    nop(); nop();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL overlap got %b want %b", o, e); end
    end
  endtask

  task automatic test_reset_md();
    logic [4:0] e, o;
    drive(1, 0, 3, 0, 3, 0, 0, 1, 1, 1, 0, 0);   // div: count 10
    nop(); nop(); nop();                         // count reaches 7
    drive(1, 0, 3, 0, 3, 6, 1, 0, 0, 1, 1, 0);   // mflo under reset
    drive(1, 0, 3, 0, 3, 6, 1, 0, 0, 1, 0, 0);   // mflo after reset
    nop(); nop();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_md got %b want %b", o, e); end
    end
  endtask

  task automatic test_perf();
    logic [4:0]  e, o;
    logic [31:0] want;
`ifdef HAZARD_STALL_PERF_EN
    want = 32'd7;
`else
    want = 32'd0;
`endif
    drive(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 1, 0);
    for (int unsigned k = 0; k < 2; k++) begin
      drive(1, 0, 3, 0, 3, 1, 2, 0, 0, 0, 0, 0);
      drive(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 1);
      drive(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0);
      nop(); nop();
    end
    drive(1, 0, 3, 0, 3, 0, 0, 1, 0, 1, 0, 0);
    for (int unsigned i = 0; i < 5; i++) drive(1, 0, 3, 0, 3, 5, 1, 0, 0, 1, 0, 1);
    drive(1, 0, 3, 0, 3, 5, 1, 0, 0, 1, 0, 0);
    nop();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL perf_seq got %b want %b", o, e); end
    end
    @(negedge clk); #1;
    checks++;
    if (perf_stall_cnt !== want) begin
      errors++; $display("FAIL perf_count got %0d want %0d", perf_stall_cnt, want);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_md(1'b0, 5);
    test_md(1'b1, 10);
    test_overlap();
    test_reset_md();
    test_perf();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
